// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad number builder.
package calc_pkg;

    typedef enum logic [1:0] {
        ENTRY,
        CONVERT,
        DONE
    } state_e;

    localparam int RADIX   = 10;
    localparam int MAX_BCD = 9;

    // RADIX**n as a 64-bit constant, used by elaboration-time range checks.
    function automatic longint unsigned pow_radix(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * longint'(RADIX);
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// 1-bit rising-edge detector; the pulse is registered so it lines up with
// any data captured on the same clock as the strobe.
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic rise_q;
    logic rise_d;

    always_comb begin
        rise_d = d & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/number_builder.sv
// Collects BCD keypad digits, then converts them serially (acc*10 + digit)
// into a signed binary value, optionally negated.
module number_builder
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MAX_DIGITS = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [3:0]                      digit,
    input  logic                            get,
    input  logic                            save,
    input  logic                            complemento,
    input  logic                            clear,
    output logic [WIDTH-1:0]                resultNumber,
    output logic                            valid,
    output logic                            busy,
    output logic                            full,
    output logic                            digit_err,
    output logic [$clog2(MAX_DIGITS+1)-1:0] digit_count
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int AW = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    // Largest enterable number must stay positive in a signed WIDTH-bit result.
    generate
        if (MAX_DIGITS > 18 ||
            (WIDTH < 64 && (pow_radix(MAX_DIGITS) - 64'd1) >= (64'd1 << (WIDTH - 1)))) begin : g_range_chk
            $error("number_builder: 10**MAX_DIGITS-1 does not fit in signed WIDTH bits");
        end
    endgenerate

    logic get_e, save_e, clear_e;

    edge_rise u_get_edge   (.clk(clk), .rst(rst), .d(get),   .rise(get_e));
    edge_rise u_save_edge  (.clk(clk), .rst(rst), .d(save),  .rise(save_e));
    edge_rise u_clear_edge (.clk(clk), .rst(rst), .d(clear), .rise(clear_e));

    // Data captured on the same clock as the strobes so it aligns with the edge pulses.
    logic [3:0]       digit_q;
    logic             comp_q;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             neg_q, neg_d;
    logic [3:0]       mem_q [2**AW];
    logic             mem_we;
    logic             full_w;
    logic [WIDTH-1:0] acc_next;

    assign full_w   = (count_q == CW'(MAX_DIGITS));
    assign acc_next = (acc_q << 3) + (acc_q << 1) + WIDTH'(mem_q[idx_q[AW-1:0]]);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        neg_d    = neg_q;
        mem_we   = 1'b0;
        if (clear_e) begin
            state_d = ENTRY;
            count_d = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ENTRY: begin
                    if (save_e) begin
                        neg_d   = comp_q;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = (count_q == '0) ? DONE : CONVERT;
                    end else if (get_e) begin
                        if (digit_q <= 4'(MAX_BCD) && !full_w) begin
                            mem_we  = 1'b1;
                            count_d = count_q + CW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    acc_d = acc_next;
                    idx_d = idx_q + CW'(1);
                    if (idx_q == count_q - CW'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    result_d = neg_q ? (~acc_q + WIDTH'(1)) : acc_q;
                    valid_d  = 1'b1;
                    count_d  = '0;
                    state_d  = ENTRY;
                end
                default: state_d = ENTRY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ENTRY;
            count_q  <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            neg_q    <= 1'b0;
            digit_q  <= '0;
            comp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            neg_q    <= neg_d;
            digit_q  <= digit;
            comp_q   <= complemento;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[count_q[AW-1:0]] <= digit_q;
        end
    end

    assign resultNumber = result_q;
    assign valid        = valid_q;
    assign busy         = (state_q == CONVERT);
    assign full         = full_w;
    assign digit_err    = err_q;
    assign digit_count  = count_q;

endmodule

// File: tb/tb_number_builder.sv
// Directed bench for number_builder with hand-computed expected values.
module tb_number_builder;

    logic        clk = 1'b0;
    logic        rst, get, save, complemento, clear;
    logic [3:0]  digit;
    logic [31:0] resultNumber;
    logic        valid, busy, full, digit_err;
    logic [3:0]  digit_count;

    int n_vec = 0;
    int n_err = 0;

    number_builder #(.WIDTH(32), .MAX_DIGITS(8)) dut (
        .clk(clk), .rst(rst), .digit(digit), .get(get), .save(save),
        .complemento(complemento), .clear(clear), .resultNumber(resultNumber),
        .valid(valid), .busy(busy), .full(full), .digit_err(digit_err),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit = d;
        get   = 1'b1;
        tick();
        get   = 1'b0;
        tick();
    endtask

    task automatic clr();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    // Save and wait for valid; latency counted in clocks from the edge that samples save.
    task automatic do_save(input string tag, input logic c, input int n, input logic [31:0] exp);
        int cyc;
        int bcnt;
        cyc  = 0;
        bcnt = 0;
        save = 1'b1;
        complemento = c;
        tick();
        save = 1'b0;
        do begin
            tick();
            cyc++;
            if (busy) bcnt++;
        end while (!valid && cyc < 40);
        chk({tag, ".latency"}, 64'(cyc), 64'(n + 2));
        chk({tag, ".busy_cycles"}, 64'(bcnt), 64'(n));
        chk({tag, ".result"}, 64'(resultNumber), 64'(exp));
        tick();
        chk({tag, ".valid_pulse"}, 64'(valid), 64'd0);
        chk({tag, ".count_after"}, 64'(digit_count), 64'd0);
        chk({tag, ".full_after"}, 64'(full), 64'd0);
        complemento = 1'b0;
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            tick();
            if (valid) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; get = 1'b0; save = 1'b0; complemento = 1'b0; clear = 1'b0; digit = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst.result", 64'(resultNumber), 64'd0);
        chk("rst.valid", 64'(valid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.full", 64'(full), 64'd0);
        chk("rst.err", 64'(digit_err), 64'd0);
        chk("rst.count", 64'(digit_count), 64'd0);

        // 1,2,3 -> 123
        key(4'd1); key(4'd2); key(4'd3);
        chk("k123.count", 64'(digit_count), 64'd3);
        do_save("k123", 1'b0, 3, 32'd123);

        // 4,5 negated -> -45
        key(4'd4); key(4'd5);
        do_save("neg45", 1'b1, 2, 32'hFFFF_FFD3);

        // Overfill: ninth key dropped and flagged
        for (int i = 1; i <= 8; i++) key(4'(i));
        chk("fill.full", 64'(full), 64'd1);
        chk("fill.err_before", 64'(digit_err), 64'd0);
        key(4'd9);
        chk("fill.err", 64'(digit_err), 64'd1);
        chk("fill.count", 64'(digit_count), 64'd8);
        do_save("fill", 1'b0, 8, 32'd12345678);
        chk("fill.err_sticky", 64'(digit_err), 64'd1);
        clr();
        chk("fill.err_cleared", 64'(digit_err), 64'd0);

        // Illegal BCD digit
        key(4'd7);
        key(4'hA);
        chk("bad.count", 64'(digit_count), 64'd1);
        chk("bad.err", 64'(digit_err), 64'd1);
        clr();
        chk("bad.err_cleared", 64'(digit_err), 64'd0);
        chk("bad.count_cleared", 64'(digit_count), 64'd0);

        // Empty buffer, negated zero is zero
        do_save("empty", 1'b1, 0, 32'd0);

        // Held get stores one digit
        digit = 4'd3;
        get   = 1'b1;
        repeat (10) tick();
        get   = 1'b0;
        tick();
        chk("held.count", 64'(digit_count), 64'd1);
        chk("held.err", 64'(digit_err), 64'd0);
        do_save("held", 1'b0, 1, 32'd3);

        // Clear shortly into an 8-digit conversion
        for (int i = 0; i < 8; i++) key(4'(9 - i));
        save = 1'b1;
        tick();
        save = 1'b0;
        tick();
        chk("clr_mid.busy_before", 64'(busy), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("clr_mid.busy", 64'(busy), 64'd0);
        chk("clr_mid.count", 64'(digit_count), 64'd0);
        chk("clr_mid.result_held", 64'(resultNumber), 64'd3);
        watch_no_valid("clr_mid.no_valid", 15);

        // Reset shortly into a conversion
        key(4'd4); key(4'd5);
        do_save("pre_rst", 1'b0, 2, 32'd45);
        for (int i = 0; i < 8; i++) key(4'(i + 1));
        save = 1'b1;
        tick();
        save = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid.result", 64'(resultNumber), 64'd0);
        chk("rst_mid.busy", 64'(busy), 64'd0);
        chk("rst_mid.count", 64'(digit_count), 64'd0);
        watch_no_valid("rst_mid.no_valid", 15);

        // Recovery after reset
        key(4'd7);
        do_save("recover", 1'b0, 1, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/number_builder.md
NUMBER_BUILDER -- requirements
Module: number_builder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, result width in bits.
REQ-002 SHALL have parameter MAX_DIGITS, default 8, digit buffer depth; 10^MAX_DIGITS-1 SHALL be < 2^(WIDTH-1), enforced by elaboration check.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port digit, input, 4, BCD keypad digit.
REQ-006 SHALL have port get, input, 1, level strobe: append digit.
REQ-007 SHALL have port save, input, 1, level strobe: commit and convert.
REQ-008 SHALL have port complemento, input, 1, negate result (two's complement), sampled on the save edge.
REQ-009 SHALL have port clear, input, 1, level strobe: discard entry.
REQ-010 SHALL have port resultNumber, output, WIDTH, converted signed value.
REQ-011 SHALL have port valid, output, 1, one-cycle pulse when resultNumber updates.
REQ-012 SHALL have port busy, output, 1, high during CONVERT.
REQ-013 SHALL have port full, output, 1, buffer holds MAX_DIGITS digits.
REQ-014 SHALL have port digit_err, output, 1, sticky: dropped or illegal digit.
REQ-015 SHALL have port digit_count, output, clog2(MAX_DIGITS+1), digits stored.

Function
REQ-016 get, save and clear SHALL act only on the rising edge of their level: the registered previous value is low and the current value is high.
REQ-017 The FSM SHALL have the states ENTRY, CONVERT and DONE, and SHALL reset to ENTRY.
REQ-018 In ENTRY, a get edge with digit<=9 and not full SHALL write mem[digit_count] and increment digit_count the next cycle.
REQ-019 A get edge with digit>9, or while full, SHALL leave the buffer unchanged and set digit_err.
REQ-020 In ENTRY, a save edge SHALL latch complemento, clear the accumulator and the index, and enter CONVERT; save SHALL win over a simultaneous get, which is dropped without setting the error.
REQ-021 CONVERT SHALL execute acc <= acc*10 + mem[idx] once per cycle for idx 0..digit_count-1, with *10 done as (acc<<3)+(acc<<1) truncated to WIDTH.
REQ-022 After the last digit, resultNumber SHALL load acc, or ~acc+1 if complemento was latched; the FSM SHALL then enter DONE and pulse valid for 1 cycle.
REQ-023 Latency from the save edge to valid SHALL be digit_count+2 cycles; save with 0 digits SHALL yield 0 (negated 0 = 0) with valid 2 cycles later.
REQ-024 DONE SHALL clear digit_count and full, then return to ENTRY after 1 cycle; resultNumber SHALL hold until the next conversion.
REQ-025 get and save edges in CONVERT or DONE SHALL be ignored and SHALL NOT set digit_err.
REQ-026 A clear edge in any state SHALL zero digit_count, full and digit_err, abort any conversion without a valid pulse, return to ENTRY and leave resultNumber unchanged.
REQ-027 full SHALL equal (digit_count==MAX_DIGITS), and busy SHALL equal (state==CONVERT).

Reset
REQ-028 rst SHALL set state=ENTRY, and SHALL set resultNumber, digit_count, the accumulator, the index and the edge-detector history to 0.
REQ-029 rst SHALL set valid, busy, full and digit_err to 0.
REQ-030 The buffer contents SHALL NOT require reset.
REQ-031 rst asserted mid-CONVERT SHALL abort the conversion with no valid pulse.

Structure
REQ-032 A shared package calc_pkg SHALL hold the state typedef, RADIX=10 and MAX_BCD=9.
REQ-033 One sub-module, edge_rise (1-bit rising-edge detector with synchronous reset), SHALL be instantiated three times.

Verification
REQ-034 Scenario: keys 1,2,3 then save with complemento=0 -> resultNumber=123, valid 5 cycles after the save edge, busy high for 3 cycles.
REQ-035 Scenario: keys 4,5 then save with complemento=1 -> resultNumber=32'hFFFFFFD3 (-45).
REQ-036 Scenario: 9 keys with MAX_DIGITS=8 -> full=1, digit_err=1; save -> 8-digit value, e.g. 12345678.
REQ-037 Scenario: digit=4'hA on get -> digit_count unchanged, digit_err=1; clear -> digit_err=0.
REQ-038 Scenario: save with 0 digits -> resultNumber=0, valid after 2 cycles.
REQ-039 Scenario: clear, or rst, 1 cycle into an 8-digit conversion -> no valid pulse, prior resultNumber held on clear or 0 on rst, state ENTRY.
REQ-040 Scenario: get held high 10 cycles -> exactly one digit stored.
